// File: rtl/chan_pkg.sv
// Shared definitions for the error-injection channel: mode encoding and LFSR feedback taps.
package chan_pkg;

    typedef enum logic [1:0] {
        MODE_CLEAN    = 2'd0,
        MODE_PERIODIC = 2'd1,
        MODE_BURST    = 2'd2,
        MODE_RANDOM   = 2'd3
    } mode_e;

    // Right-shifting Galois form of x^16+x^14+x^13+x^11+1
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

endpackage

// File: rtl/lfsr16.sv
// 16-bit Galois LFSR that steps once per asserted advance; state is the pre-step value.
module lfsr16
    import chan_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        advance,
    output logic [15:0] state
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= SEED;
        else if (advance)
            state <= {1'b0, state[15:1]} ^ (state[0] ? LFSR_TAPS : 16'h0000);
    end

endmodule

// File: rtl/error_channel.sv
// Channel model: registers each accepted symbol with a mode-selected error mask applied,
// and keeps saturating symbol / flipped-bit statistics.
module error_channel
    import chan_pkg::*;
#(
    parameter int unsigned W      = 2,
    parameter int unsigned PERIOD = 8,
    parameter int unsigned BURST  = 2,
    parameter int unsigned CNT_W  = 16,
    parameter logic [15:0] SEED   = 16'hACE1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_i,
    input  logic [W-1:0]     d_i,
    input  logic [1:0]       mode_i,
    input  logic [7:0]       thresh_i,
    input  logic             clr_stats_i,
    output logic             valid_o,
    output logic [W-1:0]     d_o,
    output logic [W-1:0]     clean_o,
    output logic [W-1:0]     err_mask_o,
    output logic [CNT_W-1:0] sym_ct_o,
    output logic [CNT_W-1:0] bit_err_ct_o
);

    localparam int PH_W = $clog2(PERIOD);
    localparam int PC_W = $clog2(W + 1);

    logic [PH_W-1:0]  phase;
    logic [15:0]      lfsr;
    logic [W-1:0]     mask;
    logic [PC_W-1:0]  pop;
    logic [CNT_W:0]   sym_nx, err_nx;
    mode_e            mode;

    assign mode = mode_e'(mode_i);

    // The LFSR steps on every accepted symbol regardless of mode, so switching
    // modes never disturbs the random sequence position.
    lfsr16 #(.SEED(SEED)) u_lfsr (
        .clk     (clk),
        .rst     (rst),
        .advance (valid_i),
        .state   (lfsr)
    );

    always_comb begin
        mask = '0;
        case (mode)
            MODE_PERIODIC: if (phase == '0)         mask[W-1] = 1'b1;
            MODE_BURST:    if (32'(phase) < BURST)  mask[W-1] = 1'b1;
            MODE_RANDOM:   if (lfsr[7:0] < thresh_i)
                               mask = W'(1) << (32'(lfsr[15:8]) % W);
            default: ;
        endcase
    end

    always_comb begin
        pop = '0;
        for (int i = 0; i < int'(W); i++)
            pop = pop + PC_W'(mask[i]);
    end

    assign sym_nx = {1'b0, sym_ct_o} + (CNT_W+1)'(1);
    assign err_nx = {1'b0, bit_err_ct_o} + (CNT_W+1)'(pop);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            phase <= '0;
        end else if (valid_i) begin
            phase <= (phase == PH_W'(PERIOD - 1)) ? '0 : phase + PH_W'(1);
        end
    end

    // Data outputs hold their last value across idle cycles; only valid_o drops.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_o    <= 1'b0;
            d_o        <= '0;
            clean_o    <= '0;
            err_mask_o <= '0;
        end else begin
            valid_o <= valid_i;
            if (valid_i) begin
                d_o        <= d_i ^ mask;
                clean_o    <= d_i;
                err_mask_o <= mask;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sym_ct_o     <= '0;
            bit_err_ct_o <= '0;
        end else if (clr_stats_i) begin
            sym_ct_o     <= '0;
            bit_err_ct_o <= '0;
        end else if (valid_i) begin
            sym_ct_o     <= sym_nx[CNT_W] ? '1 : sym_nx[CNT_W-1:0];
            bit_err_ct_o <= err_nx[CNT_W] ? '1 : err_nx[CNT_W-1:0];
        end
    end

endmodule

// File: tb/tb_error_channel.sv
// Scoreboard bench for error_channel: stimulus pushes expected outputs, a negedge monitor pops and compares.
module tb_error_channel;
    import chan_pkg::*;

    localparam int unsigned W      = 2;
    localparam int unsigned PERIOD = 8;
    localparam int unsigned BURST  = 2;
    localparam int unsigned CNT_W  = 5;   // small so saturation is reachable
    localparam logic [15:0] SEED   = 16'hACE1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             valid_i = 1'b0;
    logic [W-1:0]     d_i = '0;
    logic [1:0]       mode_i = 2'd0;
    logic [7:0]       thresh_i = 8'd0;
    logic             clr_stats_i = 1'b0;
    logic             valid_o;
    logic [W-1:0]     d_o, clean_o, err_mask_o;
    logic [CNT_W-1:0] sym_ct_o, bit_err_ct_o;

    typedef struct packed {
        logic [W-1:0] d;
        logic [W-1:0] clean;
        logic [W-1:0] mask;
    } exp_t;

    exp_t         sb[$];
    int           n_chk = 0;
    int           n_fail = 0;
    logic         last_v = 1'b0;
    logic [W-1:0] last_d = '0;
    logic [15:0]  ref_lfsr = SEED;
    logic [W-1:0] m;
    int           errs;

    error_channel #(
        .W(W), .PERIOD(PERIOD), .BURST(BURST), .CNT_W(CNT_W), .SEED(SEED)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .valid_i      (valid_i),
        .d_i          (d_i),
        .mode_i       (mode_i),
        .thresh_i     (thresh_i),
        .clr_stats_i  (clr_stats_i),
        .valid_o      (valid_o),
        .d_o          (d_o),
        .clean_o      (clean_o),
        .err_mask_o   (err_mask_o),
        .sym_ct_o     (sym_ct_o),
        .bit_err_ct_o (bit_err_ct_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference x^16+x^14+x^13+x^11+1 Galois step
    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return s[0] ? ({1'b0, s[15:1]} ^ 16'hB400) : {1'b0, s[15:1]};
    endfunction

    // W=2: bit index is lfsr[15:8] mod 2, i.e. lfsr[8]
    function automatic logic [W-1:0] rnd_mask(input logic [15:0] s, input logic [7:0] th);
        if (s[7:0] < th) return s[8] ? 2'b10 : 2'b01;
        return 2'b00;
    endfunction

    always @(negedge clk) begin
        if (rst && valid_o) begin
            if (sb.size() == 0) begin
                check("sb_unexpected_valid", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("d_o", 32'(d_o), 32'(e.d));
                check("clean_o", 32'(clean_o), 32'(e.clean));
                check("err_mask_o", 32'(err_mask_o), 32'(e.mask));
            end
        end
    end

    // One cycle of stimulus; if the previous cycle was idle, valid_o must be low and d_o held.
    task automatic send(input logic v, input logic [W-1:0] d, input logic [1:0] md,
                        input logic [7:0] th, input logic clr, input logic [W-1:0] em);
        @(posedge clk); #1;
        if (!last_v) begin
            check("idle_valid_o", 32'(valid_o), 32'd0);
            check("idle_hold_d_o", 32'(d_o), 32'(last_d));
        end
        valid_i = v; d_i = d; mode_i = md; thresh_i = th; clr_stats_i = clr;
        if (v) begin
            sb.push_back(exp_t'{d ^ em, d, em});
            last_d = d ^ em;
            ref_lfsr = lfsr_step(ref_lfsr);
        end
        last_v = v;
    endtask

    task automatic idle();
        send(1'b0, '0, 2'd0, 8'd0, 1'b0, '0);
    endtask

    task automatic do_reset();
        rst = 1'b0; valid_i = 1'b0; clr_stats_i = 1'b0;
        #1;
        check("rst_valid_o", 32'(valid_o), 32'd0);
        check("rst_d_o", 32'(d_o), 32'd0);
        check("rst_clean_o", 32'(clean_o), 32'd0);
        check("rst_err_mask_o", 32'(err_mask_o), 32'd0);
        check("rst_sym_ct", 32'(sym_ct_o), 32'd0);
        check("rst_bit_err_ct", 32'(bit_err_ct_o), 32'd0);
        sb.delete();
        last_v = 1'b0; last_d = '0; ref_lfsr = SEED;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        #2 do_reset();

        // PERIODIC: injections on symbols 0 and 8
        for (int i = 0; i < 16; i++)
            send(1'b1, 2'b01, 2'd1, 8'd0, 1'b0, (i % 8 == 0) ? 2'b10 : 2'b00);
        idle();
        check("per_bit_err_ct", 32'(bit_err_ct_o), 32'd2);
        check("per_sym_ct", 32'(sym_ct_o), 32'd16);

        // BURST: injections on 0,1,8,9
        do_reset();
        for (int i = 0; i < 16; i++)
            send(1'b1, 2'b00, 2'd2, 8'd0, 1'b0, (i % 8 < 2) ? 2'b10 : 2'b00);
        idle();
        check("burst_bit_err_ct", 32'(bit_err_ct_o), 32'd4);
        check("burst_sym_ct", 32'(sym_ct_o), 32'd16);

        // PERIODIC with valid toggling: phase advances only on accepted symbols
        do_reset();
        for (int i = 0; i < 16; i++) begin
            send(1'b1, 2'b01, 2'd1, 8'd0, 1'b0, (i % 8 == 0) ? 2'b10 : 2'b00);
            idle();
        end
        check("tog_bit_err_ct", 32'(bit_err_ct_o), 32'd2);
        check("tog_sym_ct", 32'(sym_ct_o), 32'd16);

        // RANDOM thresh 0 never injects; counters saturate at 31
        do_reset();
        for (int i = 0; i < 100; i++)
            send(1'b1, 2'(i), 2'd3, 8'd0, 1'b0, 2'b00);
        idle();
        check("rnd0_bit_err_ct", 32'(bit_err_ct_o), 32'd0);
        check("rnd0_sym_ct_sat", 32'(sym_ct_o), 32'd31);

        // RANDOM thresh 255 against reference LFSR from SEED
        do_reset();
        errs = 0;
        for (int i = 0; i < 100; i++) begin
            m = rnd_mask(ref_lfsr, 8'd255);
            if (m != 2'b00) errs++;
            send(1'b1, 2'(i), 2'd3, 8'd255, 1'b0, m);
        end
        idle();
        check("rnd255_sym_ct_sat", 32'(sym_ct_o), 32'd31);
        check("rnd255_bit_err_ct", 32'(bit_err_ct_o), (errs > 31) ? 32'd31 : 32'(errs));

        // clr_stats wins over a simultaneous increment; mode change keeps phase
        do_reset();
        for (int i = 0; i < 5; i++)
            send(1'b1, 2'b01, 2'd1, 8'd0, 1'b0, (i == 0) ? 2'b10 : 2'b00);
        send(1'b1, 2'b01, 2'd1, 8'd0, 1'b1, 2'b00);   // phase 5, clear
        idle();
        check("clr_sym_ct", 32'(sym_ct_o), 32'd0);
        check("clr_bit_err_ct", 32'(bit_err_ct_o), 32'd0);
        send(1'b1, 2'b01, 2'd1, 8'd0, 1'b0, 2'b00);   // phase 6
        send(1'b1, 2'b01, 2'd2, 8'd0, 1'b0, 2'b00);   // phase 7, now BURST
        send(1'b1, 2'b01, 2'd2, 8'd0, 1'b0, 2'b10);   // phase 0
        idle();
        check("post_clr_sym_ct", 32'(sym_ct_o), 32'd3);
        check("post_clr_bit_err_ct", 32'(bit_err_ct_o), 32'd1);

        // Reset mid-burst discards in-flight symbol; restart at phase 0
        do_reset();
        send(1'b1, 2'b00, 2'd2, 8'd0, 1'b0, 2'b10);
        send(1'b1, 2'b00, 2'd2, 8'd0, 1'b0, 2'b10);
        do_reset();
        send(1'b1, 2'b00, 2'd2, 8'd0, 1'b0, 2'b10);
        send(1'b1, 2'b00, 2'd2, 8'd0, 1'b0, 2'b10);
        send(1'b1, 2'b00, 2'd2, 8'd0, 1'b0, 2'b00);
        idle();
        check("mid_rst_sym_ct", 32'(sym_ct_o), 32'd3);
        check("mid_rst_bit_err_ct", 32'(bit_err_ct_o), 32'd2);

        repeat (3) @(posedge clk);
        #1 check("sb_empty", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
